aes_decipher_block: RTL

Word-serial AES inverse cipher datapath for AES-128 and AES-256. It is the decryption counterpart of the encipher round block and sits beside it inside the AES core. It shares the same externally expanded key memory, addressed by round number. It takes one 128-bit ciphertext block per `next` command and produces the plaintext block, applying InvSubBytes one 32-bit word per cycle through an inverse S-box.

---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_inv_sbox.sv | 30 +++
 rtl/aes_decipher_block.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the decipher datapath.
package aes_pkg;

    // Round counts by key length.
    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    // Key-length encodings as seen on the keylen input.
    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    // Decipher controller states; encodings 4..7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_SBOX = 3'd2,
        ST_MAIN = 3'd3
    } dec_state_t;

    // Number of rounds for a key-length encoding.
    function automatic logic [3:0] num_rounds(input logic kl);
        return (kl == KEYLEN_128) ? AES128_ROUNDS : AES256_ROUNDS;
    endfunction

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm8(b) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm8(b) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ gm2(b);
    endfunction

    // InvMixColumns on one column; byte 0 is the most significant byte.
    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] m0, m1, m2, m3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        m0 = gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3);
        m1 = gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3);
        m2 = gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3);
        m3 = gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3);
        return {m0, m1, m2, m3};
    endfunction

    // InvMixColumns over the whole state, one column per 32-bit word.
    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
                inv_mixw(s[63:32]),  inv_mixw(s[31:0])};
    endfunction

    // InvShiftRows: row r of the column-major state rotates right by r.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] o0, o1, o2, o3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        o0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]};
        o1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]};
        o2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]};
        o3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
        return {o0, o1, o2, o3};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Word-wide inverse S-box: four parallel byte lookups, purely combinational.
module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Each byte of the word is substituted independently.
    assign new_sword = {INV_SBOX[sword[31:24]], INV_SBOX[sword[23:16]],
                        INV_SBOX[sword[15:8]],  INV_SBOX[sword[7:0]]};

endmodule

// File: rtl/aes_decipher_block.sv
// Word-serial AES-128/256 inverse cipher. One shared inverse S-box is
// time-multiplexed over the four state words, then a single MAIN cycle does
// InvShiftRows, AddRoundKey and (except in the last round) InvMixColumns.
//
// Command handshake: 'next' is a single-cycle request honoured only while the
// controller is IDLE (ready = 1); any 'next' seen while busy, including the
// cycle in which 'ready' rises, is dropped. 'ready' high means new_block holds
// the plaintext of the last accepted command.
module aes_decipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    dec_state_t   state;
    logic [31:0]  w0, w1, w2, w3;
    logic [1:0]   sword_ctr;
    logic [3:0]   round_ctr;
    logic         keylen_reg;
    logic         ready_reg;

    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [127:0] state_blk;
    logic [127:0] addkey_blk;
    logic [127:0] mixed_blk;

    aes_inv_sbox u_inv_sbox (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    // Datapath: select the word under substitution and form the round results.
    always_comb begin
        sbox_in = w0;
        case (sword_ctr)
            2'd0: sbox_in = w0;
            2'd1: sbox_in = w1;
            2'd2: sbox_in = w2;
            2'd3: sbox_in = w3;
            default: sbox_in = w0;
        endcase
        state_blk  = {w0, w1, w2, w3};
        addkey_blk = inv_shiftrows(state_blk) ^ round_key;
        mixed_blk  = inv_mixcolumns(addkey_blk);
    end

    // Controller, counters and state words in one registered process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            w0         <= 32'h0;
            w1         <= 32'h0;
            w2         <= 32'h0;
            w3         <= 32'h0;
            sword_ctr  <= 2'd0;
            round_ctr  <= 4'd0;
            keylen_reg <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (next) begin
                        keylen_reg <= keylen;
                        round_ctr  <= num_rounds(keylen);
                        ready_reg  <= 1'b0;
                        state      <= ST_INIT;
                    end
                end

                ST_INIT: begin
                    {w0, w1, w2, w3} <= block ^ round_key;
                    round_ctr        <= num_rounds(keylen_reg) - 4'd1;
                    sword_ctr        <= 2'd0;
                    state            <= ST_SBOX;
                end

                ST_SBOX: begin
                    // InvSubBytes ahead of InvShiftRows: the two commute.
                    case (sword_ctr)
                        2'd0: w0 <= sbox_out;
                        2'd1: w1 <= sbox_out;
                        2'd2: w2 <= sbox_out;
                        2'd3: w3 <= sbox_out;
                        default: w0 <= sbox_out;
                    endcase
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3) begin
                        state <= ST_MAIN;
                    end
                end

                ST_MAIN: begin
                    if (round_ctr != 4'd0) begin
                        {w0, w1, w2, w3} <= mixed_blk;
                        round_ctr        <= round_ctr - 4'd1;
                        sword_ctr        <= 2'd0;
                        state            <= ST_SBOX;
                    end else begin
                        // Final round has no InvMixColumns.
                        {w0, w1, w2, w3} <= addkey_blk;
                        ready_reg        <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign round     = round_ctr;
    assign new_block = state_blk;
    assign ready     = ready_reg;

endmodule
